// File: rtl/led_status_ctrl_if.sv
// Status-LED bundle: asynchronous PPS/event inputs, per-channel mode words,
// and the registered LED, watchdog and tick outputs.
interface led_status_ctrl_if #(
   parameter int N_LED = 4
);
   logic                 pps;
   logic [N_LED-1:0]     evt;
   logic [3*N_LED-1:0]   mode;
   logic [N_LED-1:0]     led;
   logic                 pps_lost;
   logic                 tick;

   modport master (
      output pps, evt, mode,
      input  led, pps_lost, tick
   );

   modport slave (
      input  pps, evt, mode,
      output led, pps_lost, tick
   );
endinterface

// File: rtl/led_status_ctrl.sv
// Multi-channel status LED driver with shared tick prescaler, blink bases, pulse stretch and PPS watchdog.
// Latency: async input edge to led in 3 cycles, mode change to led in 1 cycle; no backpressure.
module led_status_ctrl #(
   parameter int N_LED             = 4,
   parameter int TICK_DIV          = 200000,
   parameter int BLINK_SLOW_TICKS  = 500,
   parameter int BLINK_FAST_TICKS  = 100,
   parameter int STRETCH_TICKS     = 50,
   parameter int PPS_TIMEOUT_TICKS = 1500
) (
   input  logic              clk200,
   input  logic              sys_reset_n,
   led_status_ctrl_if.slave  bus
);
   localparam int PW  = $clog2(TICK_DIV);
   localparam int SBW = $clog2(BLINK_SLOW_TICKS + 1);
   localparam int FBW = $clog2(BLINK_FAST_TICKS + 1);
   localparam int STW = $clog2(STRETCH_TICKS + 1);
   localparam int WDW = $clog2(PPS_TIMEOUT_TICKS + 1);

   localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [SBW-1:0] SLOW_LAST = SBW'(BLINK_SLOW_TICKS - 1);
   localparam logic [FBW-1:0] FAST_LAST = FBW'(BLINK_FAST_TICKS - 1);
   localparam logic [STW-1:0] STR_LOAD  = STW'(STRETCH_TICKS);
   localparam logic [WDW-1:0] WD_MAX    = WDW'(PPS_TIMEOUT_TICKS);

   logic [2:0]                pps_sync;
   logic [N_LED-1:0]          evt_s1, evt_s2, evt_s3;
   logic                      pps_edge;
   logic [N_LED-1:0]          evt_edge;

   logic [PW-1:0]             pre_cnt;
   logic                      tick_int;
   logic [SBW-1:0]            slow_cnt;
   logic [FBW-1:0]            fast_cnt;
   logic                      slow_ph, fast_ph;

   logic [N_LED-1:0][STW-1:0] str_cnt;
   logic [N_LED-1:0]          trig;

   logic [WDW-1:0]            wd_cnt;
   logic                      pps_edge_d;
   logic                      pps_lost_q;

   logic [N_LED-1:0]          led_d;
   logic [N_LED-1:0]          led_q;

   // Two-flop synchronisers, third flop only for rising-edge detection.
   always_ff @(posedge clk200 or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         pps_sync <= '0;
         evt_s1   <= '0;
         evt_s2   <= '0;
         evt_s3   <= '0;
      end else begin
         pps_sync <= {pps_sync[1:0], bus.pps};
         evt_s1   <= bus.evt;
         evt_s2   <= evt_s1;
         evt_s3   <= evt_s2;
      end
   end

   assign pps_edge = pps_sync[1] & ~pps_sync[2];
   assign evt_edge = evt_s2 & ~evt_s3;

   assign tick_int = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk200 or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         pre_cnt  <= '0;
         slow_cnt <= '0;
         fast_cnt <= '0;
         slow_ph  <= 1'b0;
         fast_ph  <= 1'b0;
      end else begin
         pre_cnt <= tick_int ? '0 : pre_cnt + 1'b1;
         if (tick_int) begin
            if (slow_cnt == SLOW_LAST) begin
               slow_cnt <= '0;
               slow_ph  <= ~slow_ph;
            end else begin
               slow_cnt <= slow_cnt + 1'b1;
            end
            if (fast_cnt == FAST_LAST) begin
               fast_cnt <= '0;
               fast_ph  <= ~fast_ph;
            end else begin
               fast_cnt <= fast_cnt + 1'b1;
            end
         end
      end
   end

   // Trigger source depends on the channel's current mode; other modes ignore edges.
   always_comb begin
      trig  = '0;
      led_d = '0;
      for (int i = 0; i < N_LED; i++) begin
         trig[i] = ((bus.mode[3*i +: 3] == 3'd4) && evt_edge[i]) ||
                   ((bus.mode[3*i +: 3] == 3'd5) && pps_edge);
         case (bus.mode[3*i +: 3])
            3'd0:    led_d[i] = 1'b0;
            3'd1:    led_d[i] = 1'b1;
            3'd2:    led_d[i] = slow_ph;
            3'd3:    led_d[i] = fast_ph;
            3'd4,
            3'd5:    led_d[i] = |str_cnt[i];
            3'd6:    led_d[i] = pps_lost_q ? fast_ph : 1'b1;
            default: led_d[i] = 1'b0;
         endcase
      end
   end

   // Load has priority over the tick decrement; a retrigger simply reloads.
   always_ff @(posedge clk200 or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         str_cnt <= '0;
      end else begin
         for (int i = 0; i < N_LED; i++) begin
            if (trig[i])
               str_cnt[i] <= STR_LOAD;
            else if (tick_int && (str_cnt[i] != '0))
               str_cnt[i] <= str_cnt[i] - 1'b1;
         end
      end
   end

   // pps_lost clears one cycle after the count clear so it lands 3 cycles after PPS is sampled.
   always_ff @(posedge clk200 or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         wd_cnt     <= '0;
         pps_edge_d <= 1'b0;
         pps_lost_q <= 1'b1;
      end else begin
         if (pps_edge)
            wd_cnt <= '0;
         else if (tick_int && (wd_cnt != WD_MAX))
            wd_cnt <= wd_cnt + 1'b1;
         pps_edge_d <= pps_edge;
         pps_lost_q <= (wd_cnt == WD_MAX) | (pps_lost_q & ~pps_edge_d);
      end
   end

   always_ff @(posedge clk200 or negedge sys_reset_n) begin
      if (!sys_reset_n)
         led_q <= '0;
      else
         led_q <= led_d;
   end

   assign bus.led      = led_q;
   assign bus.pps_lost = pps_lost_q;
   assign bus.tick     = tick_int;
endmodule
